// File: rtl/pwm_pkg.sv
// Shared constants for the pwm_uge timer: default width and reset fill values
// for the active period/duty registers.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;

    // Reset fill bits, replicated to the counter width at the point of use.
    localparam logic PER_RST  = 1'b1;
    localparam logic DUTY_RST = 1'b0;

endpackage

// File: rtl/pwm_uge_if.sv
// Configuration handshake bundle for pwm_uge: new period/duty offered with a
// valid (load) and accepted when the pending buffer is empty (ready).
interface pwm_uge_if #(
    parameter int WIDTH = pwm_pkg::PWM_WIDTH
);
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty;
    logic             load;
    logic             ready;

    modport master (
        output period,
        output duty,
        output load,
        input  ready
    );

    modport slave (
        input  period,
        input  duty,
        input  load,
        output ready
    );
endinterface

// File: rtl/pwm_uge_cmp.sv
// Unsigned a >= b, taken as the carry-out of a + ~b + 1 (no borrow from a - b).
module uge_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ge
);

    logic carry;

    // Ripple chain keeps only the carry, so no unused difference bits remain.
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry = (a[i] & ~b[i]) | (carry & (a[i] ^ ~b[i]));
        end
        ge = carry;
    end

endmodule

// File: rtl/pwm_uge.sv
// Up-counting PWM/timer: counts 0..per_act, output high while count < duty_act,
// with period/duty changes buffered and applied only at the wrap boundary.
import pwm_pkg::*;

module pwm_uge #(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    pwm_uge_if.slave         cfg,
    output logic [WIDTH-1:0] count,
    output logic             o,
    output logic             tc
);

    logic [WIDTH-1:0] per_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] per_pend;
    logic [WIDTH-1:0] duty_pend;
    logic             ready;
    logic             wrap;
    logic             duty_ge;

    uge_cmp #(.WIDTH(WIDTH)) u_wrap_cmp (
        .a  (count),
        .b  (per_act),
        .ge (wrap)
    );

    uge_cmp #(.WIDTH(WIDTH)) u_duty_cmp (
        .a  (count),
        .b  (duty_act),
        .ge (duty_ge)
    );

    assign cfg.ready = ready;

    // Apply requires a full buffer at the edge and accept requires an empty one,
    // so a load accepted on a wrap edge waits for the following wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            per_act   <= {WIDTH{PER_RST}};
            duty_act  <= {WIDTH{DUTY_RST}};
            per_pend  <= '0;
            duty_pend <= '0;
            ready     <= 1'b1;
            o         <= 1'b0;
            tc        <= 1'b0;
        end else begin
            if (ce) begin
                count <= wrap ? '0 : count + WIDTH'(1);
                tc    <= wrap;
                o     <= ~duty_ge;
            end else begin
                tc    <= 1'b0;
            end

            if (ce && wrap && !ready) begin
                per_act  <= per_pend;
                duty_act <= duty_pend;
                ready    <= 1'b1;
            end else if (cfg.load && ready) begin
                per_pend  <= cfg.period;
                duty_pend <= cfg.duty;
                ready     <= 1'b0;
            end
        end
    end

endmodule
